// File: rtl/pe_pkg.sv
// pe_pkg: shared width constants and one-hot helpers for the 512-way priority encoder interface
package pe_pkg;
  localparam int PE_W = 512;
  localparam int PE_IW = 9;
  function automatic logic [PE_IW-1:0] onehot2bin(input logic [PE_W-1:0] v);
    logic [PE_IW-1:0] r;
    r = '0;
    for (int i = 0; i < PE_W; i++) r |= v[i] ? PE_IW'(i) : '0;
    return r;
  endfunction
  function automatic logic is_onehot0(input logic [PE_W-1:0] v);
    return (v & (v - PE_W'(1))) == '0;
  endfunction
endpackage

// File: rtl/pe_gnt_sink_w512_onehot2bin.sv
// onehot2bin_w512: one-hot grant (vec) to index (idx) as an OR of indices, plus multi-hot flag (multi)
module onehot2bin_w512
  import pe_pkg::*;
(
  input  logic [PE_W-1:0]  vec,
  output logic [PE_IW-1:0] idx,
  output logic             multi
);
  assign idx = onehot2bin(vec);
  assign multi = ~is_onehot0(vec);
endmodule

// File: rtl/pe_gnt_sink_w512.sv
// pe_gnt_sink_w512: pending-request sink; drives Req, captures Gnt/valid as out_idx on a valid/ready stream, with busy and sticky err
module pe_gnt_sink_w512
  import pe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [PE_W-1:0]  set_vec,
  output logic [PE_W-1:0]  Req,
  input  logic [PE_W-1:0]  Gnt,
  input  logic             valid,
  output logic             out_valid,
  output logic [PE_IW-1:0] out_idx,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);
  logic [PE_W-1:0] pend;
  logic [PE_IW-1:0] gnt_idx;
  logic multi, cap, perr;
  onehot2bin_w512 u_enc (.vec(Gnt), .idx(gnt_idx), .multi(multi));
  assign Req = pend;
  assign busy = |pend | out_valid;
  assign cap = valid & (~out_valid | out_ready) & ~flush;
  assign perr = (valid != |Gnt) | multi | |(Gnt & ~pend);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= '0;
      out_valid <= 1'b0;
      out_idx <= '0;
      err <= 1'b0;
    end else begin
      pend <= flush ? set_vec : (pend & ~(cap ? Gnt : '0)) | set_vec;
      err <= err | perr;
      if (flush) out_valid <= 1'b0;
      else if (cap) begin
        out_valid <= 1'b1;
        out_idx <= gnt_idx;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_pe_gnt_sink_w512.sv
// tb_pe_gnt_sink_w512: scoreboard bench with a lowest-index-first encoder in the loop
module tb_pe_gnt_sink_w512;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [511:0] set_vec = '0;
  logic [511:0] Req, Gnt, enc_gnt;
  logic valid;
  logic out_valid, out_ready = 1'b1, busy, err;
  logic [8:0] out_idx;
  logic force_en = 1'b0;
  logic [8:0] q[$];
  int n_tests = 0;
  int n_fail = 0;
  pe_gnt_sink_w512 dut (
    .clk(clk), .rst(rst), .flush(flush), .set_vec(set_vec), .Req(Req), .Gnt(Gnt),
    .valid(valid), .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
    .busy(busy), .err(err)
  );
  assign enc_gnt = Req & (~Req + 512'd1);
  assign Gnt = force_en ? 512'h3 : enc_gnt;
  assign valid = force_en ? 1'b1 : |Req;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain(input int budget);
    int c = 0;
    while (q.size() > 0 && c < budget) begin
      step(1);
      c++;
    end
    chk("drain", 512'(q.size()), 512'd0);
  endtask
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious", 512'(out_valid), 512'd0);
      else chk("idx", 512'(out_idx), 512'(q.pop_front()));
    end
  initial begin
    int cyc;
    step(2);
    chk("rst_valid", 512'(out_valid), 512'd0);
    chk("rst_idx", 512'(out_idx), 512'd0);
    chk("rst_err", 512'(err), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_req", Req, 512'd0);
    rst = 1'b0;
    step(1);
    set_vec[5] = 1'b1;
    set_vec[300] = 1'b1;
    q.push_back(9'd5);
    q.push_back(9'd300);
    step(1);
    set_vec = '0;
    chk("lat_v0", 512'(out_valid), 512'd0);
    chk("lat_req", Req, (512'd1 << 5) | (512'd1 << 300));
    step(1);
    chk("lat_v1", 512'(out_valid), 512'd1);
    chk("lat_idx", 512'(out_idx), 512'd5);
    step(2);
    chk("a_busy", 512'(busy), 512'd0);
    out_ready = 1'b0;
    set_vec[0] = 1'b1;
    step(1);
    set_vec = '0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_v", 512'(out_valid), 512'd1);
      chk("hold_idx", 512'(out_idx), 512'd0);
      chk("hold_req0", 512'(Req[0]), 512'd0);
      if (i < 3) step(1);
    end
    out_ready = 1'b1;
    q.push_back(9'd0);
    step(1);
    chk("b_once", 512'(out_valid), 512'd0);
    drain(4);
    set_vec = '1;
    for (int i = 0; i < 512; i++) q.push_back(9'(i));
    step(1);
    set_vec = '0;
    cyc = 0;
    while (q.size() > 0 && cyc < 600) begin
      step(1);
      cyc++;
    end
    chk("full_cycles", 512'(cyc), 512'd513);
    chk("full_busy", 512'(busy), 512'd0);
    set_vec[7] = 1'b1;
    step(1);
    q.push_back(9'd7);
    q.push_back(9'd7);
    step(1);
    set_vec = '0;
    drain(10);
    chk("d_busy", 512'(busy), 512'd0);
    force_en = 1'b1;
    q.push_back(9'd1);
    step(1);
    force_en = 1'b0;
    chk("e_err", 512'(err), 512'd1);
    chk("e_idx", 512'(out_idx), 512'd1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("e_flush_v", 512'(out_valid), 512'd0);
    step(3);
    chk("e_err_sticky", 512'(err), 512'd1);
    drain(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("e_err_rst", 512'(err), 512'd0);
    set_vec[10] = 1'b1;
    set_vec[20] = 1'b1;
    set_vec[30] = 1'b1;
    step(1);
    set_vec = '0;
    step(1);
    chk("f_pre_v", 512'(out_valid), 512'd1);
    #1 rst = 1'b1;
    #1;
    chk("f_v", 512'(out_valid), 512'd0);
    chk("f_idx", 512'(out_idx), 512'd0);
    chk("f_req", Req, 512'd0);
    chk("f_busy", 512'(busy), 512'd0);
    step(1);
    rst = 1'b0;
    set_vec[42] = 1'b1;
    q.push_back(9'd42);
    step(1);
    set_vec = '0;
    drain(5);
    chk("f_busy_end", 512'(busy), 512'd0);
    chk("f_err_end", 512'(err), 512'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
